// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder
// Captures an asynchronous 7-segment pattern, waits for it to be stable for
// STABLE_CYCLES synchronized samples, then decodes it once into a digit value
// with a one-cycle valid pulse, a blank/error level and a modulo-256 count.
// Optional feature: define SEG7_DEC_HEX_EN to also decode the hex letters A-F.

module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid,
    output logic       blank,
    output logic       error,
    output logic [7:0] count
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

    logic [6:0] sync_meta;
    logic [6:0] sync_seg;
    logic [6:0] prev_seg;
    logic [6:0] last_pat;
    logic [3:0] run;
    logic [3:0] run_next;
    logic       accept;
    logic       mapped;
    logic [3:0] dec_value;

    // Two-flop synchronizer; nothing downstream looks at seg directly.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_seg  <= '0;
        end else begin
            sync_meta <= seg;
            sync_seg  <= sync_meta;
        end
    end

    // Run length of the current synchronized sample, saturating at RUN_MAX.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        run_next = run;
        if (sync_seg != prev_seg) begin
            run_next = 4'd1;
        end else if (run != RUN_MAX) begin
            run_next = run + 4'd1;
        end
    end

    // Accept only on reaching the threshold with a pattern not already accepted.
    assign accept = (run_next == RUN_MAX) && (sync_seg != last_pat);

    // Segment pattern to digit lookup; mapped is low for undecodable patterns.
    always_comb begin
        mapped    = 1'b1;
        dec_value = 4'd0;
        case (sync_seg)
            7'h3F:        dec_value = 4'd0;
            7'h06:        dec_value = 4'd1;
            7'h5B:        dec_value = 4'd2;
            7'h4F:        dec_value = 4'd3;
            7'h66:        dec_value = 4'd4;
            7'h6D:        dec_value = 4'd5;
            7'h7D:        dec_value = 4'd6;
            7'h07, 7'h27: dec_value = 4'd7;
            7'h7F:        dec_value = 4'd8;
            7'h6F, 7'h67: dec_value = 4'd9;
`ifdef SEG7_DEC_HEX_EN
            7'h77:        dec_value = 4'hA;
            7'h7C:        dec_value = 4'hB;
            7'h39:        dec_value = 4'hC;
            7'h5E:        dec_value = 4'hD;
            7'h79:        dec_value = 4'hE;
            7'h71:        dec_value = 4'hF;
`endif
            default:      mapped = 1'b0;
        endcase
    end

    // Run tracking, acceptance bookkeeping and the registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_seg <= '0;
            run      <= '0;
            last_pat <= '0;
            digit    <= '0;
            valid    <= 1'b0;
            blank    <= 1'b1;
            error    <= 1'b0;
            count    <= '0;
        end else begin
            prev_seg <= sync_seg;
            run      <= run_next;
            valid    <= 1'b0;
            if (accept) begin
                last_pat <= sync_seg;
                if (sync_seg == 7'h00) begin
                    blank <= 1'b1;
                    error <= 1'b0;
                end else if (mapped) begin
                    digit <= dec_value;
                    valid <= 1'b1;
                    count <= count + 8'd1;
                    blank <= 1'b0;
                    error <= 1'b0;
                end else begin
                    blank <= 1'b0;
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/seg7_capture_decoder.md
SEG7_CAPTURE_DECODER -- requirements
Module: seg7_capture_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, range 2..15: consecutive identical synchronized samples required before a pattern is accepted.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the port seg, input, 7 bits: segment lines, active-high, bit0=a ... bit6=g, asynchronous to clk.
REQ-005 The block SHALL have the port digit, output, 4 bits: last accepted digit value.
REQ-006 The block SHALL have the port valid, output, 1 bit: one-cycle pulse per accepted digit.
REQ-007 The block SHALL have the port blank, output, 1 bit: level, high while the last accepted pattern is 0x00.
REQ-008 The block SHALL have the port error, output, 1 bit: level, high while the last accepted pattern is not decodable.
REQ-009 The block SHALL have the port count, output, 8 bits: number of valid pulses issued, modulo 256.

Function
REQ-010 seg SHALL pass through a 2-flop synchronizer; all decisions SHALL use only synchronized samples.
REQ-011 A run counter SHALL restart whenever the synchronized sample differs from the previous one, increment otherwise, and saturate at STABLE_CYCLES.
REQ-012 A pattern SHALL be accepted once, at the first cycle its run reaches STABLE_CYCLES and it differs from the last accepted pattern; a stable pattern SHALL NOT be re-accepted.
REQ-013 Latency SHALL be fixed: if edge N first samples a new pattern that stays stable, valid SHALL be high for exactly the cycle after edge N+STABLE_CYCLES+1 (after edge N+5 at the default).
REQ-014 A change of seg before acceptance SHALL restart the run; the glitched value SHALL NOT be accepted, and no output SHALL change.
REQ-015 The digit map SHALL be: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07 or 0x27->7, 0x7F->8, 0x6F or 0x67->9.
REQ-016 On acceptance of a mapped pattern: digit updates, valid pulses, count increments, and blank and error clear, all on the same edge.
REQ-017 On acceptance of 0x00: blank sets, error clears, there is no valid pulse, and digit and count hold.
REQ-018 On acceptance of an unmapped pattern: error sets, blank clears, there is no valid pulse, and digit and count hold.
REQ-019 Because blank and error patterns update the last accepted pattern, a sequence such as 3, blank, 3 SHALL produce two valid pulses.
REQ-020 count SHALL wrap from 255 to 0 without any flag.

Reset
REQ-021 rst_n low SHALL asynchronously clear the synchronizer, run counter, digit, valid, error and count to 0, and set blank to 1.
REQ-022 The last accepted pattern SHALL reset to 0x00, so a non-blank pattern present at deassertion is accepted after the REQ-013 latency.
REQ-023 Reset asserted mid-run or mid-pulse SHALL abort the run, truncate valid, and issue no pulse afterwards for the aborted pattern.

Configuration
REQ-024 Macro SEG7_DEC_HEX_EN defined: the block SHALL additionally map 0x77->A, 0x7C->b, 0x39->C, 0x5E->d, 0x79->E, 0x71->F, with the same valid/count behaviour as REQ-016.
REQ-025 Macro SEG7_DEC_HEX_EN undefined: those six patterns SHALL be treated as unmapped per REQ-018.

Verification
REQ-026 The bench SHALL cover basic decode: reset, then seg=0x4F held 10 cycles -> digit=3, one valid pulse after edge N+5, count=1.
REQ-027 The bench SHALL cover glitch rejection: seg=0x06 held 2 cycles, then 0x5B held 8 cycles -> only digit=2 reported, one valid, count=1.
REQ-028 The bench SHALL cover re-acceptance: 0x6D, then 0x00, then 0x6D, each held 8 cycles -> two valid pulses with digit=5, blank high between them, count=2.
REQ-029 The bench SHALL cover the error path: 0x77 held 8 cycles -> error=1 without the macro (digit holds, no valid); digit=0xA with a valid pulse with the macro.
REQ-030 The bench SHALL cover wrap and reset: 256 alternating accepts of 0x06 and 0x3F -> count=0; rst_n pulsed low 3 cycles into a run -> outputs at reset values, no stray valid.
